chdr_hdr_extractor: RTL and testbench
=====================================

CHDR_HDR_EXTRACTOR -- requirements
Module: chdr_hdr_extractor

Interface
REQ-001 SHALL have parameter: STRICT_LEN, 1, enables packet-length check against the header length field.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: i_tdata  input  64  inbound CHDR word; i_tlast  input  1  last word of packet; i_tvalid  input  1  source valid; i_tready  output  1  block ready.
REQ-005 SHALL have ports: hdr_tdata  output  128  {header word, time word or 64'd0}; hdr_tvalid  output  1  header valid; hdr_tready  input  1  consumer accepts header.
REQ-006 SHALL have ports: o_tdata  output  64  payload word; o_tlast  output  1  last payload word; o_tvalid  output  1  payload valid; o_tready  input  1  payload sink ready.
REQ-007 SHALL have port: len_err  output  1  one-cycle pulse on a length mismatch.

Function
REQ-008 SHALL implement states ST_HDR, ST_TIME, ST_HOLD, ST_BODY; a transfer occurs only when valid and ready are both high in the same cycle.
REQ-009 In ST_HDR, SHALL drive i_tready=1 and capture i_tdata into hdr_tdata[127:64] on transfer, clearing hdr_tdata[63:0] to 0.
REQ-010 On an ST_HDR transfer with bit 61 (has_time)=1 and i_tlast=0, SHALL go to ST_TIME; otherwise SHALL go to ST_HOLD.
REQ-011 In ST_TIME, SHALL drive i_tready=1, capture i_tdata into hdr_tdata[63:0] on transfer, then go to ST_HOLD.
REQ-012 SHALL record whether the last captured header-phase word carried i_tlast (the "no-payload" flag).
REQ-013 In ST_HOLD, SHALL drive hdr_tvalid=1 and i_tready=0, holding hdr_tdata stable until hdr_tready=1.
REQ-014 On header acceptance, SHALL go to ST_HDR if the no-payload flag is set, else to ST_BODY; hdr_tvalid SHALL be high exactly one accepted beat per packet.
REQ-015 In ST_BODY, SHALL connect combinationally o_tdata=i_tdata, o_tlast=i_tlast, o_tvalid=i_tvalid, and i_tready=o_tready, with zero added latency.
REQ-016 On an ST_BODY transfer with i_tlast=1, SHALL return to ST_HDR.
REQ-017 Outside ST_BODY, SHALL hold o_tvalid=0 and o_tlast=0.
REQ-018 Outside ST_HOLD, SHALL hold hdr_tvalid=0.
REQ-019 SHALL keep a 13-bit beat counter of all input words of the packet (header and time included), clearing it at packet start.
REQ-020 SHALL latch length=hdr word[47:32] in ST_HDR.
REQ-021 When STRICT_LEN=1, on the i_tlast transfer SHALL compare the counter (including that beat) with ceil(length/8), computed as (length+7)>>3 in 17 bits.
REQ-022 SHALL pulse len_err for one cycle, the cycle after that final transfer, on a mismatch; the packet SHALL still be forwarded unaltered.
REQ-023 A packet with has_time=1 but i_tlast on word 0 SHALL be emitted with time=0, and SHALL raise len_err if STRICT_LEN=1 and the count mismatches.
REQ-024 When STRICT_LEN=0, len_err SHALL be constant 0.
REQ-025 A counter overflow SHALL saturate at 8191, not wrap.
REQ-026 Backpressure on hdr_tready or o_tready SHALL never drop or duplicate a word.

Reset
REQ-027 Asserting reset_n=0 at any time, including mid-packet, SHALL immediately force ST_HDR with hdr_tvalid=0, o_tvalid=0, o_tlast=0, len_err=0, hdr_tdata=0, counter=0, and flags=0.
REQ-028 After reset_n deasserts, SHALL treat the next transferred word as a header word, and SHALL raise i_tready in the first cycle after deassertion.

Verification
REQ-029 Bench SHALL cover this scenario: hdr 64'h0000_0018_0001_0002 (no time, len 24), 2 payload words, tlast on 2nd -> hdr_tdata={that word,64'd0}, 2 beats on o_*, o_tlast on the 2nd, len_err=0.
REQ-030 Bench SHALL cover this scenario: hdr with bit61=1, len 32, time 64'h1234, 2 payload words -> hdr_tdata[63:0]=64'h1234, 2 payload beats, len_err=0.
REQ-031 Bench SHALL cover this scenario: hdr_tready held 0 for 10 cycles -> i_tready=0 throughout, hdr_tdata stable, and no o_tvalid until acceptance.
REQ-032 Bench SHALL cover this scenario: header-only packet (len 8, tlast on word 0) -> one header beat, no o_tvalid, next word treated as a header.
REQ-033 Bench SHALL cover this scenario: len field 40 but tlast on 3rd word, with STRICT_LEN=1 -> all words forwarded and a single len_err pulse.
REQ-034 Bench SHALL cover this scenario: reset_n pulsed low during ST_BODY with random o_tready -> outputs reset immediately, and the following packet is parsed correctly.

Source files
------------

// File: rtl/chdr_hdr_extractor.sv
// Splits a CHDR packet into a 128-bit header beat {header, time-or-zero} and a
// pass-through payload stream, with an optional beat-count vs. length check.
module chdr_hdr_extractor #(
  parameter int unsigned STRICT_LEN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [63:0]  i_tdata,
  input  logic         i_tlast,
  input  logic         i_tvalid,
  output logic         i_tready,
  output logic [127:0] hdr_tdata,
  output logic         hdr_tvalid,
  input  logic         hdr_tready,
  output logic [63:0]  o_tdata,
  output logic         o_tlast,
  output logic         o_tvalid,
  input  logic         o_tready,
  output logic         len_err
);

  typedef enum logic [1:0] {ST_HDR, ST_TIME, ST_HOLD, ST_BODY} state_t;

  state_t        state, state_nxt;
  logic [127:0]  hdr_q;
  logic [15:0]   pkt_len;
  logic          no_payload;
  logic [12:0]   beat_cnt;
  logic [12:0]   beat_nxt;
  logic [15:0]   len_cur;
  logic [16:0]   words_exp;
  logic          mismatch;
  logic          len_err_q;
  logic          in_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_HDR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_HDR:  if (i_tvalid) state_nxt = (i_tdata[61] && !i_tlast) ? ST_TIME : ST_HOLD;
      ST_TIME: if (i_tvalid) state_nxt = ST_HOLD;
      ST_HOLD: if (hdr_tready) state_nxt = no_payload ? ST_HDR : ST_BODY;
      ST_BODY: if (i_tvalid && o_tready && i_tlast) state_nxt = ST_HDR;
      default: state_nxt = ST_HDR;
    endcase
  end

  always_comb begin
    i_tready   = 1'b0;
    hdr_tvalid = 1'b0;
    o_tvalid   = 1'b0;
    o_tlast    = 1'b0;
    unique case (state)
      ST_HDR, ST_TIME: i_tready = 1'b1;
      ST_HOLD:         hdr_tvalid = 1'b1;
      ST_BODY: begin
        i_tready = o_tready;
        o_tvalid = i_tvalid;
        o_tlast  = i_tlast;
      end
      default: i_tready = 1'b0;
    endcase
  end

  assign o_tdata   = i_tdata;
  assign hdr_tdata = hdr_q;
  assign len_err   = len_err_q;
  assign in_xfer   = i_tvalid && i_tready;

  // The header word restarts the count at 1; later beats saturate at 8191.
  always_comb begin
    if (state == ST_HDR)     beat_nxt = 13'd1;
    else if (beat_cnt == '1) beat_nxt = beat_cnt;
    else                     beat_nxt = beat_cnt + 13'd1;
  end

  // A header-only packet ends in ST_HDR, before the length is registered.
  assign len_cur   = (state == ST_HDR) ? i_tdata[47:32] : pkt_len;
  assign words_exp = ({1'b0, len_cur} + 17'd7) >> 3;
  assign mismatch  = ({4'd0, beat_nxt} != words_exp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q      <= '0;
      pkt_len    <= '0;
      no_payload <= 1'b0;
      beat_cnt   <= '0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (in_xfer) begin
        beat_cnt <= beat_nxt;
        if (i_tlast) len_err_q <= (STRICT_LEN != 0) && mismatch;
      end
      if (in_xfer && state == ST_HDR) begin
        hdr_q      <= {i_tdata, 64'd0};
        pkt_len    <= i_tdata[47:32];
        no_payload <= i_tlast;
      end
      if (in_xfer && state == ST_TIME) begin
        hdr_q[63:0] <= i_tdata;
        no_payload  <= i_tlast;
      end
    end
  end

endmodule

// File: tb/tb_chdr_hdr_extractor.sv
// Bench for chdr_hdr_extractor: packet-level reference model with queues,
// a per-cycle compare process, directed scenarios and random traffic.
module tb_chdr_hdr_extractor;

  localparam int STRICT = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [63:0]  i_tdata = '0;
  logic         i_tlast = 1'b0;
  logic         i_tvalid = 1'b0;
  logic         i_tready;
  logic [127:0] hdr_tdata;
  logic         hdr_tvalid;
  logic         hdr_tready;
  logic [63:0]  o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;
  logic         len_err;

  always #5 clk = ~clk;

  chdr_hdr_extractor #(.STRICT_LEN(STRICT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .hdr_tdata(hdr_tdata), .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .len_err(len_err)
  );

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_hdr[$];
  logic [64:0]  exp_pay[$];
  bit           exp_err[$];
  bit           exp_err_pend = 1'b0;
  int           hdr_beats = 0, o_beats = 0, err_pulses = 0;
  logic [127:0] last_hdr = '0;
  logic [63:0]  pkt[$];
  int           rdy_mode = 0;
  bit           abort = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: whole-packet view of what must come out.
  task automatic model_push();
    int n, first, len, cnt;
    bit ht;
    n  = pkt.size();
    ht = pkt[0][61] && (n > 1);
    exp_hdr.push_back({pkt[0], ht ? pkt[1] : 64'd0});
    first = ht ? 2 : 1;
    for (int i = first; i < n; i++) exp_pay.push_back({(i == n - 1), pkt[i]});
    len = int'(pkt[0][47:32]);
    cnt = (n > 8191) ? 8191 : n;
    exp_err.push_back((STRICT != 0) && (cnt != (len + 7) / 8));
  endtask

  // Ready generator
  initial begin
    hdr_tready = 1'b0;
    o_tready   = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: begin hdr_tready = ($urandom % 4) != 0; o_tready = ($urandom % 4) != 0; end
        1: begin hdr_tready = 1'b1; o_tready = 1'b1; end
        default: begin hdr_tready = 1'b0; o_tready = 1'b1; end
      endcase
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_err_pend = 1'b0;
    end else begin
      check("len_err", 128'(len_err), 128'(exp_err_pend));
      if (len_err) err_pulses++;
      exp_err_pend = 1'b0;
      if (hdr_tvalid && hdr_tready) begin
        hdr_beats++;
        last_hdr = hdr_tdata;
        if (exp_hdr.size() == 0) begin
          tests++; fails++;
          $display("FAIL hdr_unexpected got=%0h exp=none", hdr_tdata);
        end else check("hdr_tdata", hdr_tdata, 128'(exp_hdr.pop_front()));
      end
      if (o_tvalid && o_tready) begin
        o_beats++;
        if (exp_pay.size() == 0) begin
          tests++; fails++;
          $display("FAIL pay_unexpected got=%0h exp=none", {o_tlast, o_tdata});
        end else check("payload", 128'({o_tlast, o_tdata}), 128'(exp_pay.pop_front()));
      end
      if (i_tvalid && i_tready && i_tlast) begin
        if (exp_err.size() == 0) begin
          tests++; fails++;
          $display("FAIL last_unexpected got=1 exp=0");
        end else exp_err_pend = exp_err.pop_front();
      end
    end
  end

  task automatic idle(input int k);
    i_tvalid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic last);
    bit got = 1'b0;
    if (abort) return;
    i_tdata = d; i_tlast = last; i_tvalid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk); got = i_tready;
      @(posedge clk); #1;
      if (got) break;
    end
    i_tvalid = 1'b0;
    if (!got) begin
      tests++; fails++; abort = 1'b1;
      $display("FAIL word_timeout got=no_ready exp=ready data=%0h", d);
    end
  endtask

  task automatic drive_pkt(input bit gaps);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      drive_word(pkt[i], i == pkt.size() - 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hdr_tvalid"}, 128'(hdr_tvalid), 128'(0));
    check({tag, "_o_tvalid"},   128'(o_tvalid),   128'(0));
    check({tag, "_o_tlast"},    128'(o_tlast),    128'(0));
    check({tag, "_len_err"},    128'(len_err),    128'(0));
    check({tag, "_hdr_tdata"},  hdr_tdata,        128'(0));
  endtask

  int h0, o0, e0;
  task automatic snap();
    h0 = hdr_beats; o0 = o_beats; e0 = err_pulses;
  endtask
  task automatic check_deltas(input string tag, input int dh, input int dout, input int de);
    check({tag, "_hdr_beats"}, 128'(hdr_beats - h0), 128'(dh));
    check({tag, "_o_beats"},   128'(o_beats - o0),   128'(dout));
    check({tag, "_len_errs"},  128'(err_pulses - e0), 128'(de));
  endtask

  initial begin
    logic [63:0] w0;
    int n;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #3; reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(i_tready), 128'(1));
    @(posedge clk); #1;

    // No time word, len 24, two payload words
    rdy_mode = 0; snap();
    pkt = '{64'h0000_0018_0001_0002, 64'hA1, 64'hA2};
    model_push();
    check("model_hdr1", exp_hdr[$], {64'h0000_0018_0001_0002, 64'd0});
    check("model_last1", 128'(exp_pay[$]), 128'({1'b1, 64'hA2}));
    check("model_err1", 128'(exp_err[$]), 128'(0));
    drive_pkt(1'b1); idle(4);
    check("s1_hdr", last_hdr, {64'h0000_0018_0001_0002, 64'd0});
    check_deltas("s1", 1, 2, 0);

    // Time word present, len 32
    snap();
    pkt = '{64'h2000_0020_0000_0001, 64'h1234, 64'hB1, 64'hB2};
    model_push();
    check("model_time2", 128'(exp_hdr[$][63:0]), 128'(64'h1234));
    drive_pkt(1'b1); idle(4);
    check("s2_time", 128'(last_hdr[63:0]), 128'(64'h1234));
    check_deltas("s2", 1, 2, 0);

    // Header held off for 10 cycles
    rdy_mode = 2; snap();
    pkt = '{64'h0000_0018_0000_0003, 64'hC1, 64'hC2};
    model_push();
    drive_word(pkt[0], 1'b0);
    i_tdata = 64'hC1; i_tlast = 1'b0; i_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_i_tready", 128'(i_tready), 128'(0));
      check("stall_hdr_tvalid", 128'(hdr_tvalid), 128'(1));
      check("stall_hdr_tdata", hdr_tdata, {64'h0000_0018_0000_0003, 64'd0});
      check("stall_o_tvalid", 128'(o_tvalid), 128'(0));
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    drive_word(64'hC1, 1'b0);
    drive_word(64'hC2, 1'b1);
    idle(4);
    check_deltas("s3", 1, 2, 0);

    // Header-only packet, then a normal one
    rdy_mode = 0; snap();
    pkt = '{64'h0000_0008_0000_00AA};
    model_push(); drive_pkt(1'b1); idle(4);
    check_deltas("s4a", 1, 0, 0);
    snap();
    pkt = '{64'h0000_0010_0000_00BB, 64'hD1};
    model_push(); drive_pkt(1'b1); idle(4);
    check("s4b_hdr", last_hdr, {64'h0000_0010_0000_00BB, 64'd0});
    check_deltas("s4b", 1, 1, 0);

    // has_time but tlast on word 0: time forced to zero; count 1 vs len 24
    snap();
    pkt = '{64'h2000_0018_0000_00CC};
    model_push(); drive_pkt(1'b1); idle(4);
    check("s5_hdr", last_hdr, {64'h2000_0018_0000_00CC, 64'd0});
    check_deltas("s5", 1, 0, 1);
    snap();
    pkt = '{64'h2000_0008_0000_00CD};
    model_push(); drive_pkt(1'b1); idle(4);
    check_deltas("s5b", 1, 0, 0);

    // len 40 but only 3 words
    snap();
    pkt = '{64'h0000_0028_0000_0005, 64'hE1, 64'hE2};
    model_push(); drive_pkt(1'b1); idle(4);
    check_deltas("s6", 1, 2, 1);

    // Reset mid-body
    snap();
    pkt = '{64'h2000_0040_0000_0006, 64'h77, 64'hF1, 64'hF2, 64'hF3, 64'hF4, 64'hF5, 64'hF6};
    model_push();
    for (int i = 0; i < 4; i++) drive_word(pkt[i], 1'b0);
    i_tdata = 64'hF3; i_tlast = 1'b1; i_tvalid = 1'b1;
    #1;
    check("pre_reset_o_tvalid", 128'(o_tvalid), 128'(1));
    check("pre_reset_o_tlast", 128'(o_tlast), 128'(1));
    #1; reset_n = 1'b0; #1;
    check_reset_outputs("midreset");
    exp_hdr.delete(); exp_pay.delete(); exp_err.delete();
    i_tvalid = 1'b0; i_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #3; reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 128'(i_tready), 128'(1));
    @(posedge clk); #1;
    snap();
    pkt = '{64'h2000_0020_0000_0008, 64'h99, 64'hAB1, 64'hAB2};
    model_push(); drive_pkt(1'b1); idle(4);
    check("s7_hdr", last_hdr, {64'h2000_0020_0000_0008, 64'h99});
    check_deltas("s7", 1, 2, 0);

    // Counter saturation: 8200 words with len 65528 (ceil 8191) is clean only if it saturates
    rdy_mode = 1; snap();
    pkt.delete();
    pkt.push_back(64'h0000_FFF8_0000_0009);
    for (int i = 1; i < 8200; i++) pkt.push_back({$urandom, $urandom});
    model_push(); drive_pkt(1'b0); idle(4);
    check_deltas("sat", 1, 8199, 0);

    // Random traffic
    rdy_mode = 0;
    for (int p = 0; p < 40; p++) begin
      n = int'($urandom_range(1, 8));
      w0 = {$urandom, $urandom};
      w0[61] = 1'($urandom % 2);
      if (($urandom % 3) == 0) w0[47:32] = 16'($urandom);
      else                     w0[47:32] = 16'((n - 1) * 8 + int'($urandom_range(1, 8)));
      pkt.delete();
      pkt.push_back(w0);
      for (int i = 1; i < n; i++) pkt.push_back({$urandom, $urandom});
      model_push();
      drive_pkt(1'b1);
    end

    for (int c = 0; c < 1000 && (exp_hdr.size() + exp_pay.size() + exp_err.size()) != 0; c++)
      @(posedge clk);
    idle(3);
    check("queues_drained", 128'(exp_hdr.size() + exp_pay.size() + exp_err.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
